// File: rtl/atm_keypad_frontend_pkg.sv
// ---------------------------------------------------------------------------
// atm_keypad_frontend_pkg
// Shared definitions for the ATM keypad front end: FSM state encodings,
// keypad special-key codes, operation codes and a digit classifier.
// ---------------------------------------------------------------------------
package atm_keypad_frontend_pkg;

    // Front-end FSM states; the encoding is exported on fsm_state for debug.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PIN    = 3'd1,
        ST_OP     = 3'd2,
        ST_AMOUNT = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_WAIT   = 3'd5,
        ST_LOCKED = 3'd6,
        ST_EJECT  = 3'd7
    } state_t;

    // Keypad special keys (0-9 are digits, 0xD-0xF are ignored)
    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    // Operation codes presented to the ATM core
    localparam logic [2:0] OP_NONE       = 3'd0;
    localparam logic [2:0] OP_BALANCE    = 3'd1;
    localparam logic [2:0] OP_WITHDRAW   = 3'd2;
    localparam logic [2:0] OP_DEPOSIT    = 3'd3;
    localparam logic [2:0] OP_CHANGE_PIN = 3'd4;

    // Digit keys in the operation menu
    localparam logic [3:0] SEL_BALANCE    = 4'd1;
    localparam logic [3:0] SEL_WITHDRAW   = 4'd2;
    localparam logic [3:0] SEL_DEPOSIT    = 4'd3;
    localparam logic [3:0] SEL_CHANGE_PIN = 4'd4;
    localparam logic [3:0] SEL_EXIT       = 4'd5;

    // Entry limits
    localparam int PIN_DIGITS    = 4;
    localparam int AMOUNT_DIGITS = 8;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/atm_keypad_frontend_bcd_accumulator.sv
// ---------------------------------------------------------------------------
// bcd_accumulator
// Collects keypad digits into a value and counts how many were taken.
//   DECIMAL == 0 : BCD shift (value = value<<4 | digit), used for the PIN
//   DECIMAL != 0 : binary decimal (value = value*10 + digit), used for amount
// The digit limit is enforced by the caller using o_full.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          zero value and count (wins over i_digit_vld)
//   i_digit_vld      accept i_digit this cycle
//   i_digit          digit 0-9
//   o_value          accumulated value
//   o_full           count has reached MAX_DIGITS
// ---------------------------------------------------------------------------
module bcd_accumulator #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int DECIMAL    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_digit_vld,
    input  logic [3:0]       i_digit,
    output logic [WIDTH-1:0] o_value,
    output logic             o_full
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [WIDTH-1:0] r_value;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_next;

    generate
        if (DECIMAL != 0) begin : g_dec
            // x*10 as x*8 + x*2
            assign w_next = (r_value << 3) + (r_value << 1) + WIDTH'(i_digit);
        end else begin : g_bcd
            assign w_next = {r_value[WIDTH-5:0], i_digit};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_digit_vld) begin
            r_value <= w_next;
            r_count <= r_count + 1'b1;
        end
    end

    assign o_value = r_value;
    assign o_full  = (r_count == CW'(MAX_DIGITS));

endmodule

// File: rtl/atm_keypad_frontend.sv
// ---------------------------------------------------------------------------
// atm_keypad_frontend
// Turns a card-insert event and a serial keypad stream into the parallel
// request consumed by the ATM core, with PIN-failure lockout and an
// inactivity timeout that ejects the card.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   card_in, card_acc   card present level, account number from the card
//   key_valid, key_code keypad strobe and code
//   auth_fail, txn_done one-cycle feedback pulses from the core
//   acc_num, pin, operation, amount   request fields
//   req_valid           one-cycle request strobe
//   eject               one-cycle card release pulse
//   locked              high while locked out
//   fsm_state           current state for debug
// ---------------------------------------------------------------------------
module atm_keypad_frontend
    import atm_keypad_frontend_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 3,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_in,
    input  logic [3:0]  card_acc,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        auth_fail,
    input  logic        txn_done,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [2:0]  operation,
    output logic [31:0] amount,
    output logic        req_valid,
    output logic        eject,
    output logic        locked,
    output logic [2:0]  fsm_state
);

    localparam int FW = $clog2(MAX_ATTEMPTS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t          r_state;
    logic            r_card_d;
    logic [3:0]      r_acc;
    logic [2:0]      r_op;
    logic            r_req;
    logic            r_eject;
    logic            r_locked;
    logic [FW-1:0]   r_fail_cnt;
    logic [TW-1:0]   r_tmo;

    state_t          w_state_nx;
    logic            w_rise;
    logic            w_fall;
    logic            w_card_load;
    logic            w_pin_clr;
    logic            w_pin_dig;
    logic            w_pin_full;
    logic [15:0]     w_pin_val;
    logic            w_amt_clr;
    logic            w_amt_dig;
    logic            w_amt_full;
    logic [31:0]     w_amt_val;
    logic            w_op_ld;
    logic            w_op_clr;
    logic [2:0]      w_op_nx;
    logic            w_fail_clr;
    logic            w_fail_inc;
    logic [FW-1:0]   w_fail_nx;
    logic            w_tmo_state;
    logic            w_tmo_hit;

    assign w_rise      = card_in & ~r_card_d;
    assign w_fall      = ~card_in & r_card_d;
    assign w_fail_nx   = r_fail_cnt + 1'b1;
    assign w_tmo_state = (r_state == ST_PIN) || (r_state == ST_OP) ||
                         (r_state == ST_AMOUNT) || (r_state == ST_WAIT);
    assign w_tmo_hit   = (r_tmo == TMO_LAST);

    bcd_accumulator #(
        .WIDTH      (16),
        .MAX_DIGITS (PIN_DIGITS),
        .DECIMAL    (0)
    ) u_pin_acc (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_clear     (w_pin_clr),
        .i_digit_vld (w_pin_dig),
        .i_digit     (key_code),
        .o_value     (w_pin_val),
        .o_full      (w_pin_full)
    );

    bcd_accumulator #(
        .WIDTH      (32),
        .MAX_DIGITS (AMOUNT_DIGITS),
        .DECIMAL    (1)
    ) u_amt_acc (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_clear     (w_amt_clr),
        .i_digit_vld (w_amt_dig),
        .i_digit     (key_code),
        .o_value     (w_amt_val),
        .o_full      (w_amt_full)
    );

    // Next state and datapath controls
    always_comb begin
        w_state_nx  = r_state;
        w_card_load = 1'b0;
        w_pin_clr   = 1'b0;
        w_pin_dig   = 1'b0;
        w_amt_clr   = 1'b0;
        w_amt_dig   = 1'b0;
        w_op_ld     = 1'b0;
        w_op_clr    = 1'b0;
        w_op_nx     = r_op;
        w_fail_clr  = 1'b0;
        w_fail_inc  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_card_load = 1'b1;
                    w_pin_clr   = 1'b1;
                    w_fail_clr  = 1'b1;
                    w_state_nx  = ST_PIN;
                end
            end
            ST_PIN: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        w_pin_dig = ~w_pin_full;
                    end else if (key_code == KEY_CLEAR) begin
                        w_pin_clr = 1'b1;
                    end else if (key_code == KEY_ENTER) begin
                        if (w_pin_full) w_state_nx = ST_OP;
                    end else if (key_code == KEY_CANCEL) begin
                        w_state_nx = ST_EJECT;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_EJECT;
                end
            end
            ST_OP: begin
                if (key_valid) begin
                    case (key_code)
                        SEL_BALANCE: begin
                            w_op_ld    = 1'b1;
                            w_op_nx    = OP_BALANCE;
                            w_amt_clr  = 1'b1;
                            w_state_nx = ST_ISSUE;
                        end
                        SEL_WITHDRAW: begin
                            w_op_ld    = 1'b1;
                            w_op_nx    = OP_WITHDRAW;
                            w_amt_clr  = 1'b1;
                            w_state_nx = ST_AMOUNT;
                        end
                        SEL_DEPOSIT: begin
                            w_op_ld    = 1'b1;
                            w_op_nx    = OP_DEPOSIT;
                            w_amt_clr  = 1'b1;
                            w_state_nx = ST_AMOUNT;
                        end
                        SEL_CHANGE_PIN: begin
                            w_op_ld    = 1'b1;
                            w_op_nx    = OP_CHANGE_PIN;
                            w_amt_clr  = 1'b1;
                            w_state_nx = ST_ISSUE;
                        end
                        SEL_EXIT:   w_state_nx = ST_EJECT;
                        KEY_CANCEL: w_state_nx = ST_EJECT;
                        default:    ;
                    endcase
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_EJECT;
                end
            end
            ST_AMOUNT: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        w_amt_dig = ~w_amt_full;
                    end else if (key_code == KEY_CLEAR) begin
                        w_amt_clr = 1'b1;
                    end else if (key_code == KEY_ENTER) begin
                        if (w_amt_val != '0) w_state_nx = ST_ISSUE;
                    end else if (key_code == KEY_CANCEL) begin
                        w_state_nx = ST_EJECT;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_EJECT;
                end
            end
            ST_ISSUE: begin
                w_state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // A rejected PIN outranks a simultaneous completion
                if (auth_fail) begin
                    w_fail_inc = 1'b1;
                    if (w_fail_nx >= FW'(MAX_ATTEMPTS)) begin
                        w_state_nx = ST_LOCKED;
                    end else begin
                        w_pin_clr  = 1'b1;
                        w_state_nx = ST_PIN;
                    end
                end else if (txn_done) begin
                    w_state_nx = ST_OP;
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_EJECT;
                end
            end
            ST_LOCKED: begin
                if (!card_in) w_state_nx = ST_IDLE;
            end
            ST_EJECT: begin
                if (!card_in) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // Card pulled out: drop everything typed so far, keep the account
        if (w_fall && (r_state != ST_IDLE)) begin
            w_state_nx = ST_IDLE;
            w_pin_dig  = 1'b0;
            w_amt_dig  = 1'b0;
            w_op_ld    = 1'b0;
            w_fail_inc = 1'b0;
            w_pin_clr  = 1'b1;
            w_amt_clr  = 1'b1;
            w_op_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_card_d   <= 1'b0;
            r_acc      <= '0;
            r_op       <= OP_NONE;
            r_req      <= 1'b0;
            r_eject    <= 1'b0;
            r_locked   <= 1'b0;
            r_fail_cnt <= '0;
            r_tmo      <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_card_d <= card_in;
            // Strobes are registered decodes of the state being entered
            r_req    <= (w_state_nx == ST_ISSUE);
            r_locked <= (w_state_nx == ST_LOCKED);
            r_eject  <= (w_state_nx == ST_EJECT) && (r_state != ST_EJECT);

            if (w_card_load) r_acc <= card_acc;

            if (w_op_clr)     r_op <= OP_NONE;
            else if (w_op_ld) r_op <= w_op_nx;

            if (w_fail_clr)      r_fail_cnt <= '0;
            else if (w_fail_inc) r_fail_cnt <= w_fail_nx;

            // Idle counter restarts on any keypress or state change
            if (key_valid || (w_state_nx != r_state) || !w_tmo_state)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;
        end
    end

    assign acc_num   = r_acc;
    assign pin       = w_pin_val;
    assign operation = r_op;
    assign amount    = w_amt_val;
    assign req_valid = r_req;
    assign eject     = r_eject;
    assign locked    = r_locked;
    assign fsm_state = r_state;

endmodule

// File: doc/atm_keypad_frontend.md
# atm_keypad_frontend

Upstream input stage of the ATM controller. Converts a card-reader event plus a serial stream of keypad codes into the parallel request the ATM core consumes (`acc_num`, `pin`, `operation`, `amount`). Issues a one-cycle request strobe, tracks PIN failures reported back by the core, and locks the card out after too many failures. It also ejects the card on inactivity.

## Interface
- `MAX_ATTEMPTS`, default 3: PIN failures allowed before lockout.
- `TIMEOUT_CYC`, default 1000: idle cycles before abort while a card is inserted.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `card_in` in 1: card present level.
- `card_acc` in 4: account number read from the card, sampled on the `card_in` rising edge.
- `key_valid` in 1: one-cycle strobe qualifying `key_code`.
- `key_code` in 4: 0–9 are digits, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD–0xF ignored.
- `auth_fail` in 1: one-cycle pulse from the core meaning the PIN was rejected.
- `txn_done` in 1: one-cycle pulse from the core meaning the transaction finished.
- `acc_num` out 4: latched account number.
- `pin` out 16: four BCD digits, first digit entered in [15:12].
- `operation` out 3: selected operation code from the shared definitions.
- `amount` out 32: binary value of the decimal digits entered.
- `req_valid` out 1: one-cycle request strobe.
- `eject` out 1: one-cycle pulse asking the reader to release the card.
- `locked` out 1: high while the card is locked out.
- `fsm_state` out 3: current state, for debug.

## Operation
- **States:**
  - IDLE
  - PIN
  - OP
  - AMOUNT
  - ISSUE
  - WAIT
  - LOCKED
  - EJECT
- **IDLE:** on a `card_in` rising edge, latch `card_acc`, clear `pin`, clear the digit count, clear `fail_cnt`, go to PIN.
- **PIN:**
  - Each digit shifts into `pin` (left shift by 4, new digit in [3:0]) and increments the digit count.
  - A 5th or later digit is ignored.
  - CLEAR zeroes `pin` and the count.
  - ENTER with count==4 goes to OP; ENTER with count<4 is ignored.
- **OP:**
  - Digit 1 selects BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN, 5 exits to EJECT; other digits are ignored.
  - BALANCE and CHANGE_PIN go to ISSUE, with `amount`=0.
  - WITHDRAW and DEPOSIT clear `amount` and go to AMOUNT.
- **AMOUNT:**
  - Each digit updates `amount` to amount*10+digit, 8 digits max; further digits are ignored.
  - CLEAR zeroes `amount`.
  - ENTER with `amount`≠0 goes to ISSUE; ENTER with `amount`=0 is ignored.
- **ISSUE:** assert `req_valid` for exactly one cycle, then go to WAIT. Request outputs stay stable from ISSUE until the next change in PIN/OP/AMOUNT.
- **WAIT:**
  - `auth_fail` increments `fail_cnt`.
    - If `fail_cnt` reaches `MAX_ATTEMPTS`, go to LOCKED.
    - Otherwise clear `pin` and return to PIN.
  - `txn_done` returns to OP.
  - If both pulses arrive in the same cycle, `auth_fail` wins.
- **CANCEL:** in PIN, OP or AMOUNT, goes to EJECT.
- **LOCKED:** `locked`=1. All keys are ignored. Leaves to IDLE when `card_in` falls.
- **EJECT:** `eject` pulses on entry. Waits for `card_in` low, then goes to IDLE.
- **Card removed:** `card_in` falling in any state other than IDLE goes to IDLE next cycle. Key state is cleared; `acc_num` is kept.
- **Key stream:** `key_valid` is honoured only in PIN, OP and AMOUNT.

## Timing
- **Reset values:** all outputs 0, `fsm_state`=IDLE, `fail_cnt`=0, timeout counter=0.
- **Key latency:** a key accepted at edge N is visible in `pin`/`amount` and in the state after edge N.
- **Request latency:** ENTER that completes a request at edge N gives `req_valid` high during cycle N+1.
- **Timeout counter:**
  - Increments in PIN, OP, AMOUNT and WAIT.
  - Clears on any `key_valid` and on each state change.
  - Reaching `TIMEOUT_CYC`-1 goes to EJECT.
- **Reset mid-operation:** returns immediately to the reset values; the core sees no `req_valid`.

## Structure
- Key-code constants, the new state encodings and operation codes go in the shared definitions file next to the existing `ENGLISH`, `WAITING` and operation macros.
- One sub-module, `bcd_accumulator`, holds the digit count, the shift/accumulate logic and clear. It is instantiated once each for PIN and AMOUNT.
- Output registers and the FSM stay in the top module.

## Test plan
- **Nominal request:** card_in↑ with card_acc=4, keys 1,2,3,4,ENTER,2,5,0,0,ENTER → one `req_valid` pulse with acc_num=4, pin=16'h1234, operation=WITHDRAW, amount=500.
- **Entry limits:** keys 9,8,7,6,5,ENTER → pin=16'h9876. Then ENTER in AMOUNT with amount=0 → stays in AMOUNT, no `req_valid`.
- **Lockout:** three WAIT cycles each answered with `auth_fail` → locked=1 after the third, keys ignored. card_in↓ → IDLE, locked=0.
- **Timeout:** with TIMEOUT_CYC=16, no keys for 16 cycles in PIN → `eject` pulses; card_in↓ → IDLE.
- **Clash and cancel:** `auth_fail` and `txn_done` in the same cycle → PIN, fail_cnt=1. CANCEL in AMOUNT → EJECT.
- **Reset mid-request:** `rst` low during AMOUNT → all outputs 0, IDLE, no `req_valid`.
